// File: rtl/iccm_port_arbiter.sv
// ICCM port arbiter: fetch / loader req-gnt arbitration with starvation
// protection, plus exclusive BIST ownership of the ccm_controller port.
module iccm_port_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rd_valid,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_gnt,
    output logic                  l_rd_valid,
    input  logic                  bist_en,
    output logic                  bist_active,
    input  logic                  bist_rd,
    input  logic                  bist_wr,
    input  logic [ADDR_WIDTH-1:0] bist_raddr,
    input  logic [ADDR_WIDTH-1:0] bist_waddr,
    input  logic [DATA_WIDTH-1:0] bist_wdata,
    output logic                  bist_rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  c_rd,
    output logic                  c_wr,
    output logic [ADDR_WIDTH-1:0] c_raddr,
    output logic [ADDR_WIDTH-1:0] c_waddr,
    output logic [DATA_WIDTH-1:0] c_wr_data,
    input  logic [DATA_WIDTH-1:0] c_rd_data,
    input  logic                  c_rd_valid
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, DRAIN, BIST} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;

    state_t                state;
    owner_t                owner;
    logic [3:0]            starve_cnt;
    logic                  c_rd_r;
    logic                  c_wr_r;
    logic [ADDR_WIDTH-1:0] c_raddr_r;
    logic [ADDR_WIDTH-1:0] c_waddr_r;
    logic [DATA_WIDTH-1:0] c_wdata_r;

    logic starved;
    logic gnt_busy;
    logic pick_l;
    logic pick_f;
    logic rd_wait;

    assign starved  = starve_cnt >= 4'(STARVE_LIMIT);
    assign gnt_busy = f_gnt | l_gnt;
    assign pick_l   = l_req && !(f_req && starved);
    assign pick_f   = f_req && !pick_l;
    assign rd_wait  = (state == RD_WAIT) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            starve_cnt  <= '0;
            f_gnt       <= 1'b0;
            l_gnt       <= 1'b0;
            bist_active <= 1'b0;
            c_rd_r      <= 1'b0;
            c_wr_r      <= 1'b0;
            c_raddr_r   <= '0;
            c_waddr_r   <= '0;
            c_wdata_r   <= '0;
        end else begin
            f_gnt  <= 1'b0;
            l_gnt  <= 1'b0;
            c_rd_r <= 1'b0;
            c_wr_r <= 1'b0;
            if (f_gnt)
                starve_cnt <= '0;
            else if (f_req && starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;

            unique case (state)
                IDLE: begin
                    if (bist_en) begin
                        state       <= BIST;
                        bist_active <= 1'b1;
                    end else if (!gnt_busy) begin
                        if (pick_l) begin
                            l_gnt <= 1'b1;
                            if (l_we) begin
                                c_wr_r    <= 1'b1;
                                c_waddr_r <= l_addr;
                                c_wdata_r <= l_wdata;
                            end else begin
                                c_rd_r    <= 1'b1;
                                c_raddr_r <= l_addr;
                                owner     <= OWN_LOAD;
                                state     <= RD_WAIT;
                            end
                        end else if (pick_f) begin
                            f_gnt     <= 1'b1;
                            c_rd_r    <= 1'b1;
                            c_raddr_r <= f_addr;
                            owner     <= OWN_FETCH;
                            state     <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT, DRAIN: begin
                    if (c_rd_valid) begin
                        owner <= OWN_NONE;
                        if (bist_en) begin
                            state       <= BIST;
                            bist_active <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bist_en) begin
                        state <= DRAIN;
                    end
                end
                BIST: begin
                    if (!bist_en) begin
                        state       <= IDLE;
                        bist_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BIST drives the controller directly while it owns the port
    assign c_rd      = bist_active ? bist_rd    : c_rd_r;
    assign c_wr      = bist_active ? bist_wr    : c_wr_r;
    assign c_raddr   = bist_active ? bist_raddr : c_raddr_r;
    assign c_waddr   = bist_active ? bist_waddr : c_waddr_r;
    assign c_wr_data = bist_active ? bist_wdata : c_wdata_r;

    assign rd_data       = c_rd_data;
    assign f_rd_valid    = c_rd_valid && rd_wait && (owner == OWN_FETCH);
    assign l_rd_valid    = c_rd_valid && rd_wait && (owner == OWN_LOAD);
    assign bist_rd_valid = c_rd_valid && bist_active;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed-vector bench for iccm_port_arbiter.
module tb_iccm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, l_req, l_we, bist_en, bist_rd, bist_wr, c_rd_valid;
    logic [10:0] f_addr, l_addr, bist_raddr, bist_waddr;
    logic [31:0] l_wdata, bist_wdata, c_rd_data;
    logic        f_gnt, f_rd_valid, l_gnt, l_rd_valid;
    logic        bist_active, bist_rd_valid, c_rd, c_wr;
    logic [31:0] rd_data, c_wr_data;
    logic [10:0] c_raddr, c_waddr;

    int checks = 0;
    int errors = 0;

    iccm_port_arbiter #(
        .ADDR_WIDTH(11), .DATA_WIDTH(32), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rd_valid(f_rd_valid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rd_valid(l_rd_valid),
        .bist_en(bist_en), .bist_active(bist_active),
        .bist_rd(bist_rd), .bist_wr(bist_wr),
        .bist_raddr(bist_raddr), .bist_waddr(bist_waddr),
        .bist_wdata(bist_wdata), .bist_rd_valid(bist_rd_valid),
        .rd_data(rd_data), .c_rd(c_rd), .c_wr(c_wr),
        .c_raddr(c_raddr), .c_waddr(c_waddr),
        .c_wr_data(c_wr_data), .c_rd_data(c_rd_data),
        .c_rd_valid(c_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 0; f_req = 0; l_req = 0; l_we = 0; bist_en = 0;
        bist_rd = 0; bist_wr = 0; c_rd_valid = 0;
        f_addr = 0; l_addr = 0; bist_raddr = 0; bist_waddr = 0;
        l_wdata = 0; bist_wdata = 0; c_rd_data = 0;
        #2;
        chk("rst_f_gnt", 32'(f_gnt), 0);
        chk("rst_l_gnt", 32'(l_gnt), 0);
        chk("rst_c_rd", 32'(c_rd), 0);
        chk("rst_c_wr", 32'(c_wr), 0);
        chk("rst_bist_active", 32'(bist_active), 0);
        chk("rst_c_raddr", 32'(c_raddr), 0);
        tick(); tick();
        rst_n = 1;
        tick();

        // fetch read
        f_req = 1; f_addr = 11'h010;
        tick();
        chk("f_gnt", 32'(f_gnt), 1);
        chk("f_c_rd", 32'(c_rd), 1);
        chk("f_c_raddr", 32'(c_raddr), 32'h010);
        tick();
        f_req = 0;
        chk("f_gnt_1cyc", 32'(f_gnt), 0);
        chk("f_c_rd_1cyc", 32'(c_rd), 0);
        c_rd_valid = 1; c_rd_data = 32'hDEADBEEF;
        #1;
        chk("f_rd_valid", 32'(f_rd_valid), 1);
        chk("f_rd_data", rd_data, 32'hDEADBEEF);
        chk("f_l_rd_valid", 32'(l_rd_valid), 0);
        tick();
        c_rd_valid = 0;
        #1;
        chk("f_rd_valid_off", 32'(f_rd_valid), 0);

        // loader write held for three cycles
        l_req = 1; l_we = 1; l_addr = 11'h7FF; l_wdata = 32'hA5A5A5A5;
        tick();
        chk("lw_gnt", 32'(l_gnt), 1);
        chk("lw_c_wr", 32'(c_wr), 1);
        chk("lw_c_waddr", 32'(c_waddr), 32'h7FF);
        chk("lw_c_wdata", c_wr_data, 32'hA5A5A5A5);
        chk("lw_c_rd", 32'(c_rd), 0);
        tick();
        chk("lw_no_double", 32'(l_gnt), 0);
        chk("lw_c_wr_off", 32'(c_wr), 0);
        tick();
        chk("lw_second_gnt", 32'(l_gnt), 1);
        l_req = 0;
        tick();
        chk("lw_gnt_off", 32'(l_gnt), 0);

        // starvation: both held, loader wins twice then fetch
        f_req = 1; f_addr = 11'h044; l_req = 1;
        tick();
        chk("st1_l", 32'(l_gnt), 1);
        chk("st1_f", 32'(f_gnt), 0);
        tick();
        chk("st2_l", 32'(l_gnt), 0);
        tick();
        chk("st3_l", 32'(l_gnt), 1);
        chk("st3_f", 32'(f_gnt), 0);
        tick();
        chk("st4_l", 32'(l_gnt), 0);
        tick();
        chk("st5_f", 32'(f_gnt), 1);
        chk("st5_l", 32'(l_gnt), 0);
        chk("st5_raddr", 32'(c_raddr), 32'h044);
        f_req = 0; l_req = 0;
        tick();
        chk("st_cnt_clr", 32'(dut.starve_cnt), 0);
        c_rd_valid = 1; c_rd_data = 32'h00C0FFEE;
        #1;
        chk("st_f_rd_valid", 32'(f_rd_valid), 1);
        tick();
        c_rd_valid = 0;

        // fetch read interrupted by BIST request
        f_req = 1; f_addr = 11'h020;
        tick();
        chk("bd_f_gnt", 32'(f_gnt), 1);
        f_req = 0; bist_en = 1; l_req = 1; l_we = 1;
        tick();
        chk("bd_no_l_gnt", 32'(l_gnt), 0);
        chk("bd_not_active", 32'(bist_active), 0);
        tick();
        chk("bd_no_l_gnt2", 32'(l_gnt), 0);
        c_rd_valid = 1; c_rd_data = 32'h12345678;
        #1;
        chk("bd_f_rd_valid", 32'(f_rd_valid), 1);
        chk("bd_bist_rv_off", 32'(bist_rd_valid), 0);
        tick();
        c_rd_valid = 0;
        chk("bd_active", 32'(bist_active), 1);
        chk("bd_l_gnt_bist", 32'(l_gnt), 0);
        bist_rd = 1; bist_raddr = 11'h123;
        bist_wr = 1; bist_waddr = 11'h055; bist_wdata = 32'h0BADF00D;
        #1;
        chk("bd_c_rd", 32'(c_rd), 1);
        chk("bd_c_raddr", 32'(c_raddr), 32'h123);
        chk("bd_c_wr", 32'(c_wr), 1);
        chk("bd_c_waddr", 32'(c_waddr), 32'h055);
        chk("bd_c_wdata", c_wr_data, 32'h0BADF00D);
        c_rd_valid = 1;
        #1;
        chk("bd_bist_rv", 32'(bist_rd_valid), 1);
        chk("bd_f_rv_bist", 32'(f_rd_valid), 0);
        tick();
        c_rd_valid = 0; bist_rd = 0; bist_wr = 0; l_req = 0;

        // BIST release with fetch pending
        f_req = 1; f_addr = 11'h030;
        tick();
        chk("bx_f_gnt_bist", 32'(f_gnt), 0);
        bist_en = 0;
        tick();
        chk("bx_inactive", 32'(bist_active), 0);
        chk("bx_f_gnt0", 32'(f_gnt), 0);
        tick();
        chk("bx_f_gnt", 32'(f_gnt), 1);
        chk("bx_raddr", 32'(c_raddr), 32'h030);
        f_req = 0;
        tick();

        // reset while a read is outstanding
        rst_n = 0;
        #1;
        chk("rr_c_rd", 32'(c_rd), 0);
        chk("rr_c_raddr", 32'(c_raddr), 0);
        chk("rr_f_gnt", 32'(f_gnt), 0);
        chk("rr_active", 32'(bist_active), 0);
        tick();
        rst_n = 1;
        c_rd_valid = 1; c_rd_data = 32'h55AA55AA;
        #1;
        chk("rr_f_rv", 32'(f_rd_valid), 0);
        chk("rr_l_rv", 32'(l_rd_valid), 0);
        chk("rr_b_rv", 32'(bist_rd_valid), 0);
        tick();
        c_rd_valid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
Shares the single ICCM ccm_controller port between three requesters: instruction fetch (read-only), the program loader/debug port (read or write), and the ICCM BIST engine. Fetch and loader use a req/gnt handshake with fixed priority and starvation protection; BIST takes exclusive ownership while bist_en is high. It sits between the PC/fetch logic and ccm_controller, replacing the bare bist_en mux.

Parameters:
ADDR_WIDTH, 11, word address width (2048 words)
DATA_WIDTH, 32, data width
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch gets priority (range 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request; held until f_gnt
f_addr  in  ADDR_WIDTH  fetch read address
f_gnt  out  1  one-cycle fetch grant
f_rd_valid  out  1  fetch read data valid
l_req  in  1  loader request; held until l_gnt
l_we  in  1  loader: 1 = write, 0 = read
l_addr  in  ADDR_WIDTH  loader address
l_wdata  in  DATA_WIDTH  loader write data
l_gnt  out  1  one-cycle loader grant
l_rd_valid  out  1  loader read data valid
bist_en  in  1  BIST ownership request
bist_active  out  1  BIST owns the port
bist_rd, bist_wr  in  1 each  BIST commands
bist_raddr, bist_waddr  in  ADDR_WIDTH each  BIST addresses
bist_wdata  in  DATA_WIDTH  BIST write data
bist_rd_valid  out  1  BIST read data valid
rd_data  out  DATA_WIDTH  c_rd_data broadcast to all requesters
c_rd, c_wr  out  1 each  controller commands
c_raddr, c_waddr  out  ADDR_WIDTH each  controller addresses
c_wr_data  out  DATA_WIDTH  controller write data
c_rd_data  in  DATA_WIDTH  controller read data
c_rd_valid  in  1  controller read valid

Behaviour:
- Reset: state IDLE; all gnt, valid, c_rd, c_wr, bist_active = 0; addresses and data = 0; starve counter = 0; read owner = none.
- States: IDLE, RD_WAIT, DRAIN, BIST.
- IDLE, arbitration at each edge with no gnt currently high:
  - Loader beats fetch unless starve_cnt >= STARVE_LIMIT, in which case fetch wins.
  - Winner's gnt and matching c_* command are registered, so both are high together for exactly one cycle after the sampling edge.
  - In the gnt-high cycle, req is ignored, so a held request cannot be double-granted.
- Loader write: c_wr, c_waddr and c_wr_data are asserted for one cycle; state stays IDLE.
- Any read: c_rd and c_raddr are asserted for one cycle; the read owner is recorded; go to RD_WAIT.
- RD_WAIT:
  - No grants are issued.
  - On c_rd_valid, pulse the owner's *_rd_valid combinationally in the same cycle, clear the owner, and return to IDLE.
  - Only one read is ever outstanding.
- Starvation counter (4-bit, saturating):
  - Increments each cycle f_req is high and f_gnt is not asserted.
  - Clears on f_gnt.
  - Holds while f_req is low.
- bist_en rising or high:
  - From IDLE, go directly to BIST.
  - From RD_WAIT, go to DRAIN. DRAIN waits for c_rd_valid, delivers it to the owner, then enters BIST.
  - No new grants are issued once bist_en is high.
- BIST:
  - bist_active = 1.
  - c_* follow bist_* combinationally.
  - c_rd_valid is routed to bist_rd_valid.
  - f_gnt and l_gnt stay 0.
- bist_en falling in BIST: bist_active drops at the next edge, state returns to IDLE, and pending requests are arbitrated normally.
- A simultaneous grant edge and bist_en rise: the grant already registered completes; BIST entry follows per the rules above.
- Reset mid-operation: return immediately to reset values; any outstanding read is abandoned, and a late c_rd_valid in IDLE is ignored.
- c_rd_valid arriving in IDLE is dropped with no valid pulse.

Test Plan:
- Fetch only, f_addr=0x010 → f_gnt and c_rd with c_raddr=0x010 one cycle after sampling; c_rd_valid with c_rd_data=0xDEADBEEF → f_rd_valid=1, rd_data=0xDEADBEEF.
- Loader write l_addr=0x7FF, l_wdata=0xA5A5A5A5 → one-cycle l_gnt, c_wr with c_waddr=0x7FF and c_wr_data=0xA5A5A5A5; next grant possible two cycles later.
- f_req and l_req (writes) held continuously, STARVE_LIMIT=4 → loader granted until fetch has been denied 4 cycles, then fetch granted; counter = 0 afterwards.
- Fetch read in RD_WAIT, bist_en=1 before c_rd_valid → no grants; f_rd_valid on the return; then bist_active=1, and bist_rd/bist_raddr=0x123 appear on c_rd/c_raddr.
- bist_en drops with f_req pending → bist_active=0, then f_gnt follows.
- rst_n low during RD_WAIT → all outputs 0 immediately; a c_rd_valid after reset produces no *_rd_valid.
